pingpong_fill_writer: RTL and testbench

Write-side companion to the ping/pong sub-block readers. It accepts a byte stream with a valid/ready handshake and packs it into two 16-entry banks, A (ping) and B (pong), filling them alternately. It presents completed banks to the reader stage as parallel `a00..a15` / `b00..b15` vectors, together with the `pingpong` select, the `aneedpang`/`bneedpang` flags and the start/end index signals. The reader returns each consumed bank with a release pulse.

---
 rtl/pingpong_pkg.sv | 28 ++
 rtl/pingpong_bank_fill.sv | 90 +++++++++
 rtl/pingpong_fill_writer.sv | 106 ++++++++++
 tb/tb_pingpong_fill_writer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping/pong fill writer.
//   bank_state_t : per-bank fill state (EMPTY, FILLING, FULL)
//   pp_beat_t    : one input stream beat as seen by a bank
//   PP_A / PP_B  : encodings of the bank select (1 = A, 0 = B)
package pingpong_pkg;

  localparam int unsigned PP_DEPTH  = 16;
  localparam int unsigned PP_IDX_W  = 4;
  localparam int unsigned PP_DATA_W = 8;

  localparam logic [PP_IDX_W-1:0] PP_IDX_LAST = PP_IDX_W'(PP_DEPTH - 1);

  localparam logic PP_A = 1'b1;
  localparam logic PP_B = 1'b0;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  typedef struct packed {
    logic [PP_DATA_W-1:0] data;
    logic                 last;
    logic [PP_IDX_W-1:0]  startofs;
  } pp_beat_t;

endpackage

// File: rtl/pingpong_bank_fill.sv
// One 16x8 bank with its fill state machine.
// Optional feature: define PINGPONG_ZERO_FILL_EN to clear every entry outside
// [startinc, endinc] on the closing edge.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   wr_en        : a beat is offered to this bank this cycle
//   beat         : data / last / start offset of the offered beat
//   rel_en       : the reader releases this bank (only acted on when FULL)
//   mem          : bank contents
//   needpang     : bank closed as a partial block
//   startinc     : first written index
//   endinc       : last written index
//   full_c       : bank is FULL (decoded from state)
//   close_c      : this cycle's beat closes the bank
module pingpong_bank_fill
  import pingpong_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  pp_beat_t                              beat,
  input  logic                                  rel_en,
  output logic [PP_DEPTH-1:0][PP_DATA_W-1:0]    mem,
  output logic                                  needpang,
  output logic [PP_IDX_W-1:0]                   startinc,
  output logic [PP_IDX_W-1:0]                   endinc,
  output logic                                  full_c,
  output logic                                  close_c
);

  bank_state_t         state;
  bank_state_t         state_nx;
  logic [PP_IDX_W-1:0] wptr;
  logic [PP_IDX_W-1:0] cur_ptr;
  logic [PP_IDX_W-1:0] cur_start;
  logic                accept;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  end

  // Next state; the first beat of a block takes its index from the offset
  always_comb begin
    state_nx  = state;
    cur_ptr   = (state == EMPTY) ? beat.startofs : wptr;
    cur_start = (state == EMPTY) ? beat.startofs : startinc;
    accept    = wr_en && (state != FULL);
    close_c   = accept && ((cur_ptr == PP_IDX_LAST) || beat.last);
    full_c    = (state == FULL);
    case (state)
      EMPTY, FILLING: if (accept) state_nx = close_c ? FULL : FILLING;
      FULL:           if (rel_en) state_nx = EMPTY;
      default:        state_nx = EMPTY;
    endcase
  end

  // Storage, write pointer and block descriptor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem      <= '0;
      wptr     <= '0;
      startinc <= '0;
      endinc   <= '0;
      needpang <= 1'b0;
    end else begin
      if (accept) begin
        mem[cur_ptr] <= beat.data;
        endinc       <= cur_ptr;
        wptr         <= cur_ptr + PP_IDX_W'(1);
        if (state == EMPTY) startinc <= beat.startofs;
        if (close_c) begin
          needpang <= (cur_start != '0) || (cur_ptr != PP_IDX_LAST);
`ifdef PINGPONG_ZERO_FILL_EN
          // A block never wraps, so the written range is contiguous
          for (int unsigned i = 0; i < PP_DEPTH; i++) begin
            if ((PP_IDX_W'(i) < cur_start) || (PP_IDX_W'(i) > cur_ptr))
              mem[i] <= '0;
          end
`else
`endif
        end
      end
      // Release only reaches a FULL bank, which never accepts in the same cycle
      if (rel_en && (state == FULL)) needpang <= 1'b0;
    end
  end

endmodule

// File: rtl/pingpong_fill_writer.sv
// Packs a valid/ready byte stream into two alternating 16-entry banks
// (A = ping, B = pong) and presents completed banks to the reader.
// Optional feature: PINGPONG_ZERO_FILL_EN zero-pads partial banks on close.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  : input stream handshake
//   in_last                    : close the current bank early
//   in_startofs                : start offset, sampled on a bank's first beat
//   a00..a15, b00..b15         : bank contents
//   aneedpang, bneedpang       : bank holds a partial block
//   a/bneedpangstartinc/endinc : first / last written index
//   pingpong                   : presented bank, 1 = A, 0 = B
//   rd_valid                   : presented bank is FULL
//   rd_release                 : reader is done with the presented bank
module pingpong_fill_writer
  import pingpong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic [3:0] in_startofs,
  output logic [7:0] a00, a01, a02, a03, a04, a05, a06, a07,
  output logic [7:0] a08, a09, a10, a11, a12, a13, a14, a15,
  output logic [7:0] b00, b01, b02, b03, b04, b05, b06, b07,
  output logic [7:0] b08, b09, b10, b11, b12, b13, b14, b15,
  output logic       aneedpang,
  output logic       bneedpang,
  output logic [3:0] aneedpangstartinc,
  output logic [3:0] bneedpangstartinc,
  output logic [3:0] aneedpangendinc,
  output logic [3:0] bneedpangendinc,
  output logic       pingpong,
  output logic       rd_valid,
  input  logic       rd_release
);

  logic [PP_DEPTH-1:0][PP_DATA_W-1:0] a_mem;
  logic [PP_DEPTH-1:0][PP_DATA_W-1:0] b_mem;
  pp_beat_t beat;
  logic     wsel;
  logic     a_full_c, b_full_c;
  logic     a_close_c, b_close_c;
  logic     accept, rel_ok;

  assign beat.data     = in_data;
  assign beat.last     = in_last;
  assign beat.startofs = in_startofs;

  // Handshake and release steering
  assign in_ready = (wsel == PP_A) ? !a_full_c : !b_full_c;
  assign rd_valid = (pingpong == PP_A) ? a_full_c : b_full_c;
  assign accept   = in_valid && in_ready;
  assign rel_ok   = rd_release && rd_valid;

  pingpong_bank_fill u_bank_a (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && (wsel == PP_A)),
    .beat     (beat),
    .rel_en   (rel_ok && (pingpong == PP_A)),
    .mem      (a_mem),
    .needpang (aneedpang),
    .startinc (aneedpangstartinc),
    .endinc   (aneedpangendinc),
    .full_c   (a_full_c),
    .close_c  (a_close_c)
  );

  pingpong_bank_fill u_bank_b (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && (wsel == PP_B)),
    .beat     (beat),
    .rel_en   (rel_ok && (pingpong == PP_B)),
    .mem      (b_mem),
    .needpang (bneedpang),
    .startinc (bneedpangstartinc),
    .endinc   (bneedpangendinc),
    .full_c   (b_full_c),
    .close_c  (b_close_c)
  );

  // Write and read bank selects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wsel     <= PP_A;
      pingpong <= PP_A;
    end else begin
      if (a_close_c || b_close_c) wsel <= ~wsel;
      if (rel_ok)                 pingpong <= ~pingpong;
    end
  end

  assign a00 = a_mem[0];  assign a01 = a_mem[1];  assign a02 = a_mem[2];  assign a03 = a_mem[3];
  assign a04 = a_mem[4];  assign a05 = a_mem[5];  assign a06 = a_mem[6];  assign a07 = a_mem[7];
  assign a08 = a_mem[8];  assign a09 = a_mem[9];  assign a10 = a_mem[10]; assign a11 = a_mem[11];
  assign a12 = a_mem[12]; assign a13 = a_mem[13]; assign a14 = a_mem[14]; assign a15 = a_mem[15];
  assign b00 = b_mem[0];  assign b01 = b_mem[1];  assign b02 = b_mem[2];  assign b03 = b_mem[3];
  assign b04 = b_mem[4];  assign b05 = b_mem[5];  assign b06 = b_mem[6];  assign b07 = b_mem[7];
  assign b08 = b_mem[8];  assign b09 = b_mem[9];  assign b10 = b_mem[10]; assign b11 = b_mem[11];
  assign b12 = b_mem[12]; assign b13 = b_mem[13]; assign b14 = b_mem[14]; assign b15 = b_mem[15];

endmodule

// File: tb/tb_pingpong_fill_writer.sv
// Self-checking bench for pingpong_fill_writer: directed table, hand-written
// corner sequences and randomized traffic against a bank-level reference model.
module tb_pingpong_fill_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_last = 1'b0;
  logic [3:0] in_startofs = '0;
  logic [7:0] da [16];
  logic [7:0] db [16];
  logic       aneedpang, bneedpang;
  logic [3:0] aneedpangstartinc, bneedpangstartinc;
  logic [3:0] aneedpangendinc, bneedpangendinc;
  logic       pingpong, rd_valid;
  logic       rd_release = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pingpong_fill_writer dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_startofs(in_startofs),
    .a00(da[0]),  .a01(da[1]),  .a02(da[2]),  .a03(da[3]),
    .a04(da[4]),  .a05(da[5]),  .a06(da[6]),  .a07(da[7]),
    .a08(da[8]),  .a09(da[9]),  .a10(da[10]), .a11(da[11]),
    .a12(da[12]), .a13(da[13]), .a14(da[14]), .a15(da[15]),
    .b00(db[0]),  .b01(db[1]),  .b02(db[2]),  .b03(db[3]),
    .b04(db[4]),  .b05(db[5]),  .b06(db[6]),  .b07(db[7]),
    .b08(db[8]),  .b09(db[9]),  .b10(db[10]), .b11(db[11]),
    .b12(db[12]), .b13(db[13]), .b14(db[14]), .b15(db[15]),
    .aneedpang(aneedpang), .bneedpang(bneedpang),
    .aneedpangstartinc(aneedpangstartinc), .bneedpangstartinc(bneedpangstartinc),
    .aneedpangendinc(aneedpangendinc), .bneedpangendinc(bneedpangendinc),
    .pingpong(pingpong), .rd_valid(rd_valid), .rd_release(rd_release)
  );

  // Reference model: bank index 0 = A, 1 = B
  logic [7:0] m_mem [2][16];
  bit         m_full [2];
  bit         m_open [2];
  bit         m_np [2];
  int         m_ptr [2];
  int         m_start [2];
  int         m_end [2];
  int         m_wsel;
  int         m_pp;

  function automatic void m_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) m_mem[b][i] = 8'h00;
      m_full[b] = 0; m_open[b] = 0; m_np[b] = 0;
      m_ptr[b] = 0; m_start[b] = 0; m_end[b] = 0;
    end
    m_wsel = 0;
    m_pp   = 0;
  endfunction

  function automatic void m_step(input logic v, input logic last, input logic [3:0] ofs,
                                 input logic [7:0] d, input logic rel);
    bit rdy = !m_full[m_wsel];
    bit rdv = m_full[m_pp];
    int b, p;
    if (v && rdy) begin
      b = m_wsel;
      p = m_open[b] ? m_ptr[b] : int'(ofs);
      if (!m_open[b]) m_start[b] = int'(ofs);
      m_open[b]   = 1;
      m_mem[b][p] = d;
      m_end[b]    = p;
      m_ptr[b]    = p + 1;
      if (p == 15 || last) begin
        m_full[b] = 1;
        m_open[b] = 0;
        m_np[b]   = (m_start[b] != 0) || (p != 15);
`ifdef PINGPONG_ZERO_FILL_EN
        for (int i = 0; i < 16; i++)
          if (i < m_start[b] || i > p) m_mem[b][i] = 8'h00;
`endif
        m_wsel = 1 - b;
      end
    end
    if (rel && rdv) begin
      m_full[m_pp] = 0;
      m_np[m_pp]   = 0;
      m_pp         = 1 - m_pp;
    end
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every registered output with the model
  task automatic check_state();
    logic [127:0] ga, gb, ea, eb;
    logic [18:0]  gf, ef;
    for (int i = 0; i < 16; i++) begin
      ga[i*8 +: 8] = da[i];
      gb[i*8 +: 8] = db[i];
      ea[i*8 +: 8] = m_mem[0][i];
      eb[i*8 +: 8] = m_mem[1][i];
    end
    gf = {aneedpang, bneedpang, aneedpangstartinc, bneedpangstartinc,
          aneedpangendinc, bneedpangendinc, pingpong};
    ef = {m_np[0], m_np[1], 4'(m_start[0]), 4'(m_start[1]),
          4'(m_end[0]), 4'(m_end[1]), (m_pp == 0)};
    chk("bank_a", ga, ea);
    chk("bank_b", gb, eb);
    chk("flags", 128'(gf), 128'(ef));
  endtask

  // One clock: drive, check decoded outputs, advance model, check registers
  task automatic cycle(input logic v, input logic last, input logic [3:0] ofs,
                       input logic [7:0] d, input logic rel);
    in_valid = v; in_last = last; in_startofs = ofs; in_data = d; rd_release = rel;
    #1;
    chk("in_ready", 128'(in_ready), 128'(!m_full[m_wsel]));
    chk("rd_valid", 128'(rd_valid), 128'(m_full[m_pp]));
    m_step(v, last, ofs, d, rel);
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    in_valid = 0; in_last = 0; in_startofs = '0; in_data = '0; rd_release = 0;
    reset = 1'b0;
    m_reset();
    #1;
    check_state();
    chk("rst_rd_valid", 128'(rd_valid), 128'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
  endtask

  task automatic full_fill_check(input string tag);
    logic [127:0] ga, ea;
    for (int i = 0; i < 16; i++) cycle(1, 0, 4'd0, 8'(i), 0);
    for (int i = 0; i < 16; i++) begin
      ga[i*8 +: 8] = da[i];
      ea[i*8 +: 8] = 8'(i);
    end
    chk({tag, "_a_data"}, ga, ea);
    chk({tag, "_aneedpang"}, 128'(aneedpang), 128'(1'b0));
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(1'b1));
    chk({tag, "_pingpong"}, 128'(pingpong), 128'(1'b1));
    cycle(1, 0, 4'd0, 8'h99, 0);
    chk({tag, "_b00"}, 128'(db[0]), 128'(8'h99));
  endtask

  typedef struct {
    logic       v;
    logic       last;
    logic [3:0] ofs;
    logic [7:0] d;
    logic       rel;
    logic       e_rdy;
    logic       e_rdv;
    logic       e_pp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [127:0] ga, ea;

    tbl[0]  = '{0, 0, 4'd0,  8'h00, 1, 1, 0, 1}; // release with nothing full
    tbl[1]  = '{1, 0, 4'd14, 8'h11, 0, 1, 0, 1};
    tbl[2]  = '{1, 0, 4'd0,  8'h12, 0, 1, 0, 1}; // A closes at index 15
    tbl[3]  = '{1, 0, 4'd15, 8'h21, 0, 1, 1, 1}; // B closes as 1-entry block
    tbl[4]  = '{1, 0, 4'd0,  8'h31, 0, 0, 1, 1}; // both full: stall
    tbl[5]  = '{1, 0, 4'd0,  8'h31, 1, 0, 1, 1}; // release A
    tbl[6]  = '{1, 0, 4'd0,  8'h31, 0, 1, 1, 0}; // lands in A
    tbl[7]  = '{1, 1, 4'd0,  8'h32, 1, 1, 1, 0}; // close A + release B
    tbl[8]  = '{1, 0, 4'd0,  8'h41, 0, 1, 1, 1};
    tbl[9]  = '{1, 1, 4'd0,  8'h42, 1, 1, 1, 1}; // close B + release A
    tbl[10] = '{1, 0, 4'd5,  8'h51, 0, 1, 1, 0}; // accepted into A
    tbl[11] = '{0, 0, 4'd0,  8'h00, 0, 1, 1, 0};

    #2;
    do_reset();

    // Full 16-beat fill at offset 0
    full_fill_check("s1");

    // Partial block: offset 3, five beats
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, (i == 4), 4'd3, 8'hA0 + 8'(i), 0);
    chk("s2_start", 128'(aneedpangstartinc), 128'(4'd3));
    chk("s2_end", 128'(aneedpangendinc), 128'(4'd7));
    chk("s2_needpang", 128'(aneedpang), 128'(1'b1));
    for (int i = 0; i < 16; i++) begin
      ga[i*8 +: 8] = da[i];
      ea[i*8 +: 8] = (i >= 3 && i <= 7) ? 8'hA0 + 8'(i - 3) : 8'h00;
    end
    chk("s2_a_data", ga, ea);

    // Directed table: stalls, releases, same-cycle close and release
    do_reset();
    for (int r = 0; r < 12; r++) begin
      in_valid = tbl[r].v; in_last = tbl[r].last; in_startofs = tbl[r].ofs;
      in_data = tbl[r].d; rd_release = tbl[r].rel;
      #1;
      chk($sformatf("tbl%0d_in_ready", r), 128'(in_ready), 128'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_rd_valid", r), 128'(rd_valid), 128'(tbl[r].e_rdv));
      chk($sformatf("tbl%0d_pingpong", r), 128'(pingpong), 128'(tbl[r].e_pp));
      cycle(tbl[r].v, tbl[r].last, tbl[r].ofs, tbl[r].d, tbl[r].rel);
    end

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of a fill, then a clean fill
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 0, 4'd0, 8'h70 + 8'(i), 0);
    do_reset();
    full_fill_check("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
